// File: rtl/connect_vc_pkg.sv
// Shared types and default sizes for the multi-VC injection port.
package connect_vc_pkg;

  localparam int unsigned VC_BITS_DEF     = 1;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned CREDIT_INIT_DEF = 4;
  localparam int unsigned FLIT_WIDTH_DEF  = 32;

  localparam int unsigned FLIT_VALID_BIT = FLIT_WIDTH_DEF - 1;
  localparam int unsigned VC_FIELD_LSB   = 0;
  localparam int unsigned VC_FIELD_MSB   = VC_FIELD_LSB + VC_BITS_DEF - 1;

  typedef logic [VC_BITS_DEF-1:0]             vc_t;
  typedef logic [$clog2(CREDIT_INIT_DEF):0]   credit_t;

  typedef struct packed {
    logic valid;
    vc_t  vc;
  } credit_ret_t;

endpackage

// File: rtl/vc_flit_fifo.sv
// Single-VC registered FIFO; full/empty disambiguated by a maybe_full bit.
module vc_flit_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              enq_valid,
  output logic              enq_ready,
  output logic [DATA_W-1:0] deq_data,
  output logic              deq_valid,
  input  logic              deq_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_enq_ptr;
  logic [PTR_W-1:0]  r_deq_ptr;
  logic              r_maybe_full;

  logic w_ptr_eq;
  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_ptr_eq  = (r_enq_ptr == r_deq_ptr);
  assign w_full    = w_ptr_eq && r_maybe_full;
  assign w_empty   = w_ptr_eq && !r_maybe_full;
  assign enq_ready = !w_full;
  assign deq_valid = !w_empty;
  assign deq_data  = r_mem[r_deq_ptr];
  assign w_enq     = enq_valid && !w_full;
  assign w_deq     = deq_ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_enq) r_enq_ptr <= r_enq_ptr + PTR_W'(1);
      if (w_deq) r_deq_ptr <= r_deq_ptr + PTR_W'(1);
      if (w_enq != w_deq) r_maybe_full <= w_enq;
    end
  end

  // Storage is data only; reset discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_enq_ptr] <= enq_data;
  end

endmodule

// File: rtl/multi_vc_in_port_fifo.sv
// Multi-VC injection port: per-VC FIFOs, per-VC credit counters and a
// round-robin arbiter driving the router putFlit/getCredits interface.
module multi_vc_in_port_fifo
  import connect_vc_pkg::*;
#(
  parameter int unsigned NUM_VCS     = 2,
  parameter int unsigned VC_BITS     = VC_BITS_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned CREDIT_INIT = CREDIT_INIT_DEF,
  parameter int unsigned FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter int unsigned VC_LSB      = VC_FIELD_LSB
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic [VC_BITS-1:0]    put_vc,
  input  logic                  put_flit_valid,
  output logic [NUM_VCS-1:0]    put_flit_ready,
  output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  output logic                  EN_send_ports_putFlit,
  input  logic [VC_BITS:0]      send_ports_getCredits,
  output logic                  EN_send_ports_getCredits,
  output logic                  credit_err
);

  localparam int unsigned CRED_W = $clog2(CREDIT_INIT) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDIT_INIT);

  typedef struct packed {
    logic               valid;
    logic [VC_BITS-1:0] vc;
  } cret_t;

  cret_t                 w_ret;
  logic                  w_put_vc_ok;
  logic                  w_ret_vc_ok;
  logic [NUM_VCS-1:0]    w_enq_valid;
  logic [NUM_VCS-1:0]    w_enq_ready;
  logic [NUM_VCS-1:0]    w_deq_valid;
  logic [NUM_VCS-1:0]    w_elig;
  logic [NUM_VCS-1:0]    w_send;
  logic [NUM_VCS-1:0]    w_ret_hit;
  logic [NUM_VCS-1:0]    w_ovf;
  logic [FLIT_WIDTH-1:0] w_deq_data [NUM_VCS];
  logic                  w_grant_vld;
  logic [VC_BITS-1:0]    w_grant;
  logic [FLIT_WIDTH-1:0] w_flit;
  logic                  w_err_set;

  logic [CRED_W-1:0]     r_credits [NUM_VCS];
  logic [VC_BITS-1:0]    r_ptr;
  logic                  r_credit_err;

  assign w_ret       = send_ports_getCredits;
  assign w_put_vc_ok = (32'(put_vc) < NUM_VCS);
  assign w_ret_vc_ok = (32'(w_ret.vc) < NUM_VCS);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign w_enq_valid[v] = put_flit_valid && w_put_vc_ok && (put_vc == VC_BITS'(v));
    assign w_ret_hit[v]   = w_ret.valid && w_ret_vc_ok && (w_ret.vc == VC_BITS'(v));
    assign w_send[v]      = w_grant_vld && (w_grant == VC_BITS'(v));
    assign w_elig[v]      = w_deq_valid[v] && (r_credits[v] != '0);
    assign w_ovf[v]       = w_ret_hit[v] && !w_send[v] && (r_credits[v] == CRED_MAX);

    vc_flit_fifo #(
      .DATA_W (FLIT_WIDTH),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST_N),
      .enq_data  (put_flit),
      .enq_valid (w_enq_valid[v]),
      .enq_ready (w_enq_ready[v]),
      .deq_data  (w_deq_data[v]),
      .deq_valid (w_deq_valid[v]),
      .deq_ready (w_send[v])
    );
  end

  assign put_flit_ready = w_enq_ready;

  // Lowest eligible VC at/after ptr wins; otherwise wrap to the lowest eligible.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int j = int'(NUM_VCS) - 1; j >= 0; j--) begin
      if (w_elig[j]) begin
        w_grant_vld = 1'b1;
        w_grant     = VC_BITS'(j);
      end
    end
    for (int j = int'(NUM_VCS) - 1; j >= 0; j--) begin
      if (w_elig[j] && (j >= int'(r_ptr))) w_grant = VC_BITS'(j);
    end
  end

  always_comb begin
    w_flit = '0;
    if (w_grant_vld) begin
      w_flit                     = w_deq_data[w_grant];
      w_flit[FLIT_WIDTH-1]       = 1'b1;
      w_flit[VC_LSB +: VC_BITS]  = w_grant;
    end
  end

  assign send_ports_putFlit_flit_in = w_flit;
  assign EN_send_ports_putFlit      = w_grant_vld;
  assign EN_send_ports_getCredits   = 1'b1;

  assign w_err_set = (|w_ovf)
                   || (put_flit_valid && !w_put_vc_ok)
                   || (w_ret.valid && !w_ret_vc_ok);

  // Send and return on the same VC cancel; overflowing returns saturate.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int v = 0; v < int'(NUM_VCS); v++) r_credits[v] <= CRED_MAX;
    end else begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        if (w_send[v] && !w_ret_hit[v])
          r_credits[v] <= r_credits[v] - CRED_W'(1);
        else if (w_ret_hit[v] && !w_send[v] && (r_credits[v] != CRED_MAX))
          r_credits[v] <= r_credits[v] + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr        <= '0;
      r_credit_err <= 1'b0;
    end else begin
      if (w_grant_vld)
        r_ptr <= (32'(w_grant) == NUM_VCS - 1) ? '0 : w_grant + VC_BITS'(1);
      if (w_err_set) r_credit_err <= 1'b1;
    end
  end

  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_multi_vc_in_port_fifo.sv
// Directed bench for multi_vc_in_port_fifo (NUM_VCS=2, DEPTH=4, CREDIT_INIT=4).
module tb_multi_vc_in_port_fifo;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] put_flit;
  logic [0:0]  put_vc;
  logic        put_flit_valid;
  logic [1:0]  put_flit_ready;
  logic [31:0] send_ports_putFlit_flit_in;
  logic        EN_send_ports_putFlit;
  logic [1:0]  send_ports_getCredits;
  logic        EN_send_ports_getCredits;
  logic        credit_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] fair_flit [8] = '{32'h0, 32'h8000_0300, 32'h8000_0201, 32'h8000_0302,
                                 32'h8000_0203, 32'h8000_0304, 32'h8000_0205, 32'h8000_0306};
  logic        fair_ptr  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  multi_vc_in_port_fifo #(
    .NUM_VCS     (2),
    .VC_BITS     (1),
    .DEPTH       (4),
    .CREDIT_INIT (4),
    .FLIT_WIDTH  (32),
    .VC_LSB      (0)
  ) dut (
    .CLK                        (CLK),
    .RST_N                      (RST_N),
    .put_flit                   (put_flit),
    .put_vc                     (put_vc),
    .put_flit_valid             (put_flit_valid),
    .put_flit_ready             (put_flit_ready),
    .send_ports_putFlit_flit_in (send_ports_putFlit_flit_in),
    .EN_send_ports_putFlit      (EN_send_ports_putFlit),
    .send_ports_getCredits      (send_ports_getCredits),
    .EN_send_ports_getCredits   (EN_send_ports_getCredits),
    .credit_err                 (credit_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    put_flit              = '0;
    put_vc                = '0;
    put_flit_valid        = 1'b0;
    send_ports_getCredits = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic vc, input logic [31:0] data);
    put_flit       = data;
    put_vc         = vc;
    put_flit_valid = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 64'(put_flit_ready), 64'h3);
    chk("rst_en", 64'(EN_send_ports_putFlit), 64'h0);
    chk("rst_flit", 64'(send_ports_putFlit_flit_in), 64'h0);
    chk("rst_err", 64'(credit_err), 64'h0);
    chk("rst_cred0", 64'(dut.r_credits[0]), 64'h4);
    chk("rst_en_getcred", 64'(EN_send_ports_getCredits), 64'h1);
    RST_N = 1'b1;
    tick();

    // single flit on VC1
    put(1'b1, 32'h0000_00A5);
    tick();
    idle();
    chk("single_en", 64'(EN_send_ports_putFlit), 64'h1);
    chk("single_flit", 64'(send_ports_putFlit_flit_in), 64'h8000_00A5);
    chk("single_cred1_pre", 64'(dut.r_credits[1]), 64'h4);
    tick();
    chk("single_cred1", 64'(dut.r_credits[1]), 64'h3);
    chk("single_en_after", 64'(EN_send_ports_putFlit), 64'h0);

    // credit exhaustion on VC0
    for (int i = 0; i < 5; i++) begin
      put(1'b0, 32'(32'h10 + 2 * i));
      tick();
      chk($sformatf("exh_en%0d", i), 64'(EN_send_ports_putFlit), (i < 4) ? 64'h1 : 64'h0);
      chk($sformatf("exh_flit%0d", i), 64'(send_ports_putFlit_flit_in),
          (i < 4) ? 64'(32'h8000_0010 + 2 * i) : 64'h0);
    end
    idle();
    chk("exh_cred0", 64'(dut.r_credits[0]), 64'h0);
    chk("exh_ready", 64'(put_flit_ready), 64'h3);
    tick();
    tick();
    chk("exh_hold_en", 64'(EN_send_ports_putFlit), 64'h0);
    send_ports_getCredits = 2'b10;
    #1;
    chk("ret_same_cycle_en", 64'(EN_send_ports_putFlit), 64'h0);
    tick();
    idle();
    chk("ret_en", 64'(EN_send_ports_putFlit), 64'h1);
    chk("ret_flit", 64'(send_ports_putFlit_flit_in), 64'h8000_0018);
    chk("ret_cred0", 64'(dut.r_credits[0]), 64'h1);
    tick();
    chk("ret_en_after", 64'(EN_send_ports_putFlit), 64'h0);
    chk("ret_cred0_after", 64'(dut.r_credits[0]), 64'h0);

    // fairness: drain VC1 credits, leave three VC1 flits queued
    do_reset();
    for (int i = 0; i < 7; i++) begin
      put(1'b1, (i < 4) ? 32'(32'h101 + 2 * i) : 32'(32'h201 + 2 * (i - 4)));
      tick();
    end
    idle();
    chk("fair_pre_cred1", 64'(dut.r_credits[1]), 64'h0);
    chk("fair_pre_cred0", 64'(dut.r_credits[0]), 64'h4);
    chk("fair_pre_en", 64'(EN_send_ports_putFlit), 64'h0);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        put(1'b0, 32'(32'h300 + 2 * c));
        send_ports_getCredits = 2'b11;
      end else begin
        idle();
      end
      chk($sformatf("fair_ptr%0d", c), 64'(dut.r_ptr), 64'(fair_ptr[c]));
      chk($sformatf("fair_en%0d", c), 64'(EN_send_ports_putFlit), (c != 0) ? 64'h1 : 64'h0);
      chk($sformatf("fair_flit%0d", c), 64'(send_ports_putFlit_flit_in), 64'(fair_flit[c]));
      tick();
    end
    idle();
    chk("fair_cred0", 64'(dut.r_credits[0]), 64'h0);
    chk("fair_cred1", 64'(dut.r_credits[1]), 64'h1);
    chk("fair_en_end", 64'(EN_send_ports_putFlit), 64'h0);

    // full FIFO on VC0 with no credits
    for (int i = 0; i < 4; i++) begin
      put(1'b0, 32'(32'h400 + 2 * i));
      tick();
    end
    idle();
    chk("full_ready", 64'(put_flit_ready), 64'h2);
    chk("full_en", 64'(EN_send_ports_putFlit), 64'h0);
    put(1'b0, 32'h0000_04EE);
    chk("full_put5_ready", 64'(put_flit_ready), 64'h2);
    tick();
    idle();
    chk("full_put5_after", 64'(put_flit_ready), 64'h2);
    put(1'b1, 32'h0000_0501);
    tick();
    idle();
    chk("full_vc1_en", 64'(EN_send_ports_putFlit), 64'h1);
    chk("full_vc1_flit", 64'(send_ports_putFlit_flit_in), 64'h8000_0501);
    chk("full_vc1_ready", 64'(put_flit_ready), 64'h2);
    tick();
    for (int k = 0; k < 6; k++) begin
      send_ports_getCredits = (k < 5) ? 2'b10 : 2'b00;
      chk($sformatf("drain_en%0d", k), 64'(EN_send_ports_putFlit),
          (k >= 1 && k <= 4) ? 64'h1 : 64'h0);
      chk($sformatf("drain_flit%0d", k), 64'(send_ports_putFlit_flit_in),
          (k >= 1 && k <= 4) ? 64'(32'h8000_0400 + 2 * (k - 1)) : 64'h0);
      tick();
    end
    idle();
    chk("drain_cred0", 64'(dut.r_credits[0]), 64'h1);

    // simultaneous send and return on VC0 at credits=2
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(1'b0, 32'(32'h600 + 2 * i));
      tick();
    end
    idle();
    chk("sim_cred0_pre", 64'(dut.r_credits[0]), 64'h2);
    chk("sim_flit", 64'(send_ports_putFlit_flit_in), 64'h8000_0604);
    send_ports_getCredits = 2'b10;
    tick();
    idle();
    chk("sim_cred0", 64'(dut.r_credits[0]), 64'h2);
    chk("sim_en_after", 64'(EN_send_ports_putFlit), 64'h0);

    // credit overflow
    send_ports_getCredits = 2'b10;
    tick();
    tick();
    chk("ovf_cred0_full", 64'(dut.r_credits[0]), 64'h4);
    chk("ovf_err_pre", 64'(credit_err), 64'h0);
    tick();
    idle();
    chk("ovf_err", 64'(credit_err), 64'h1);
    chk("ovf_cred0", 64'(dut.r_credits[0]), 64'h4);
    tick();
    chk("ovf_err_sticky", 64'(credit_err), 64'h1);

    // asynchronous reset mid-stream
    put(1'b1, 32'h0000_0701);
    tick();
    idle();
    chk("arst_pre_en", 64'(EN_send_ports_putFlit), 64'h1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_en", 64'(EN_send_ports_putFlit), 64'h0);
    chk("arst_flit", 64'(send_ports_putFlit_flit_in), 64'h0);
    chk("arst_err", 64'(credit_err), 64'h0);
    chk("arst_cred1", 64'(dut.r_credits[1]), 64'h4);
    chk("arst_ready", 64'(put_flit_ready), 64'h3);
    tick();
    RST_N = 1'b1;
    tick();
    chk("arst_discard_en", 64'(EN_send_ports_putFlit), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
